// File: rtl/ins_check_gate.sv
// ============================================================================
// ins_check_gate
// ----------------------------------------------------------------------------
// Instruction check/release gate for the alert path.
//
// Tracked instructions arrive together with a check code and are buffered in
// a small FIFO. Each one bumps a saturating reference count. An untracked beat
// is a release request. It drains the buffered instructions downstream, but
// only when the pass checker says so (pass_ok) and enough tracked instructions
// have been seen (ref_cnt >= REF_THRESH). Any other release request is a fault.
// A fault flushes the FIFO, clears the reference count, bumps the fault count
// and pulses alert for one cycle.
//
// Optional feature (macro ICG_TIMEOUT_EN):
//   When defined, a watchdog counts consecutive RELEASE cycles in which the
//   head beat is offered but not taken. When that count reaches TIMEOUT_CYC
//   the gate faults. When undefined, RELEASE waits for downstream forever and
//   TIMEOUT_CYC has no effect.
//
// Ports:
//   clk        in   1      clock
//   RST        in   1      reset, asynchronous, active-high
//   in_valid   in   1      input beat valid
//   in_ready   out  1      input beat accepted when in_valid & in_ready
//   in_ins     in   INS_W  instruction
//   in_trk     in   1      1 = tracked instruction, 0 = release request
//   in_chk     in   CHK_W  check code of a tracked beat
//   pass_ok    in   1      pass-checker verdict, sampled on a release beat
//   out_valid  out  1      output beat valid
//   out_ready  in   1      downstream accept
//   out_ins    out  INS_W  released instruction (FIFO head), 0 when idle
//   out_chk    out  CHK_W  check code paired with out_ins, 0 when idle
//   alert      out  1      one-cycle pulse on fault
//   fault_cnt  out  8      saturating fault count
//   ref_cnt    out  REF_W  saturating tracked-instruction count
// ============================================================================
module ins_check_gate #(
    parameter int INS_W       = 64,
    parameter int CHK_W       = 16,
    parameter int REF_W       = 13,
    parameter int REF_THRESH  = 5000,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [INS_W-1:0] in_ins,
    input  logic             in_trk,
    input  logic [CHK_W-1:0] in_chk,
    input  logic             pass_ok,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INS_W-1:0] out_ins,
    output logic [CHK_W-1:0] out_chk,
    output logic             alert,
    output logic [7:0]       fault_cnt,
    output logic [REF_W-1:0] ref_cnt
);

    // ------------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------------
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [REF_W-1:0] C_THRESH  = REF_W'(REF_THRESH);
    localparam logic [CNT_W-1:0] C_DEPTH   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] C_ONE_CNT = CNT_W'(1);
    localparam logic [PTR_W-1:0] C_ONE_PTR = PTR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_RELEASE = 2'd2,
        S_FAULT   = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_next;

    logic [INS_W-1:0] r_mem_ins [FIFO_DEPTH];
    logic [CHK_W-1:0] r_mem_chk [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic [7:0]       r_fault_cnt;
    logic [REF_W-1:0] r_ref_cnt;

    logic             w_full;
    logic             w_in_open;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic             w_last;
    logic             w_rel_ok;
    logic             w_to_fault;
    logic             w_wd_expire;
    logic [INS_W-1:0] w_head_ins;
    logic [CHK_W-1:0] w_head_chk;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    assign w_full    = (r_count == C_DEPTH);
    assign w_in_open = (r_state == S_IDLE) || (r_state == S_ARMED);

    // A release request must get through even with a full buffer, otherwise a
    // full FIFO could never be drained.
    assign in_ready  = w_in_open && (!in_trk || !w_full);
    assign w_accept  = in_valid && in_ready;
    assign w_push    = w_accept && in_trk;

    assign out_valid = (r_state == S_RELEASE);
    assign w_pop     = out_valid && out_ready;
    assign w_last    = (r_count == C_ONE_CNT);

    // Uses the count as it stands this cycle; a push cannot coincide with a
    // release beat anyway since both arrive on the single input port.
    assign w_rel_ok  = pass_ok && (r_ref_cnt >= C_THRESH);

    // ------------------------------------------------------------------------
    // Release watchdog
    // ------------------------------------------------------------------------
`ifdef ICG_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [WD_W-1:0] C_WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [WD_W-1:0] C_WD_ONE  = WD_W'(1);

    logic [WD_W-1:0] r_wd_cnt;

    // The stall in which the count would reach TIMEOUT_CYC is the last one
    // tolerated; the FSM leaves RELEASE on that edge.
    assign w_wd_expire = out_valid && !out_ready && (r_wd_cnt == C_WD_LAST);

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_wd_cnt <= '0;
        end else if (out_valid && !out_ready && !w_wd_expire) begin
            r_wd_cnt <= r_wd_cnt + C_WD_ONE;
        end else begin
            // Any pop, any non-RELEASE cycle or the expiry itself restarts it.
            r_wd_cnt <= '0;
        end
    end
`else
    logic w_unused_timeout;

    assign w_wd_expire      = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYC != 0);
`endif

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and fault decision
    // ------------------------------------------------------------------------
    // w_to_fault marks the edge that enters FAULT. The flush and counter
    // updates are applied on that edge so that, during the alert cycle, the
    // counters and the empty FIFO are already visible.
    always_comb begin
        w_state_next = r_state;
        w_to_fault   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (in_trk) begin
                        w_state_next = S_ARMED;
                    end else begin
                        // Release request with nothing armed.
                        w_state_next = S_FAULT;
                        w_to_fault   = 1'b1;
                    end
                end
            end

            S_ARMED: begin
                if (w_accept && !in_trk) begin
                    if (w_rel_ok) begin
                        w_state_next = S_RELEASE;
                    end else begin
                        w_state_next = S_FAULT;
                        w_to_fault   = 1'b1;
                    end
                end
            end

            S_RELEASE: begin
                if (w_pop && w_last) begin
                    w_state_next = S_IDLE;
                end else if (w_wd_expire) begin
                    w_state_next = S_FAULT;
                    w_to_fault   = 1'b1;
                end
            end

            S_FAULT: begin
                w_state_next = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FIFO storage (no reset needed: contents are only observed through the
    // valid-gated output mux)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_ins[r_wr_ptr] <= in_ins;
            r_mem_chk[r_wr_ptr] <= in_chk;
        end
    end

    assign w_head_ins = r_mem_ins[r_rd_ptr];
    assign w_head_chk = r_mem_chk[r_rd_ptr];

    // ------------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ------------------------------------------------------------------------
    // Push happens only in IDLE/ARMED and pop only in RELEASE, so the two are
    // mutually exclusive and the occupancy update needs no combined case.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_to_fault) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_push) begin
            r_wr_ptr <= r_wr_ptr + C_ONE_PTR;
            r_count  <= r_count + C_ONE_CNT;
        end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + C_ONE_PTR;
            r_count  <= r_count - C_ONE_CNT;
        end
    end

    // ------------------------------------------------------------------------
    // Reference and fault counters
    // ------------------------------------------------------------------------
    // ref_cnt survives a successful release; only a fault or reset clears it.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_ref_cnt   <= '0;
            r_fault_cnt <= '0;
        end else if (w_to_fault) begin
            r_ref_cnt <= '0;
            if (r_fault_cnt != 8'hFF) begin
                r_fault_cnt <= r_fault_cnt + 8'd1;
            end
        end else if (w_push && (r_ref_cnt != {REF_W{1'b1}})) begin
            r_ref_cnt <= r_ref_cnt + REF_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign out_ins   = out_valid ? w_head_ins : '0;
    assign out_chk   = out_valid ? w_head_chk : '0;
    assign alert     = (r_state == S_FAULT);
    assign fault_cnt = r_fault_cnt;
    assign ref_cnt   = r_ref_cnt;

endmodule

// File: tb/tb_ins_check_gate.sv
// ============================================================================
// tb_ins_check_gate
// ----------------------------------------------------------------------------
// Bench for ins_check_gate built with REF_THRESH=3, REF_W=4 (so saturation of
// ref_cnt is reachable), FIFO_DEPTH=4 and TIMEOUT_CYC=8.
//
// The reference model is kept as plain queues: "pend" holds tracked beats not
// yet released, "sb" holds beats promised to downstream. The gate is idle when
// pend is empty, armed when it is not, and releasing while sb is non-empty.
// The driver updates the model from each accepted beat; a separate monitor
// compares every offered output beat against the head of sb.
// ============================================================================
module tb_ins_check_gate;

    localparam int INS_W = 64;
    localparam int CHK_W = 16;
    localparam int REFW  = 4;
    localparam int THR   = 3;
    localparam int DEPTH = 4;
    localparam int TO    = 8;
    localparam int REF_MAX = (1 << REFW) - 1;

    logic             clk;
    logic             RST;
    logic             in_valid;
    logic             in_ready;
    logic [INS_W-1:0] in_ins;
    logic             in_trk;
    logic [CHK_W-1:0] in_chk;
    logic             pass_ok;
    logic             out_valid;
    logic             out_ready;
    logic [INS_W-1:0] out_ins;
    logic [CHK_W-1:0] out_chk;
    logic             alert;
    logic [7:0]       fault_cnt;
    logic [REFW-1:0]  ref_cnt;

    ins_check_gate #(
        .INS_W      (INS_W),
        .CHK_W      (CHK_W),
        .REF_W      (REFW),
        .REF_THRESH (THR),
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk      (clk),
        .RST      (RST),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ins   (in_ins),
        .in_trk   (in_trk),
        .in_chk   (in_chk),
        .pass_ok  (pass_ok),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ins  (out_ins),
        .out_chk  (out_chk),
        .alert    (alert),
        .fault_cnt(fault_cnt),
        .ref_cnt  (ref_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [INS_W-1:0] ins;
        logic [CHK_W-1:0] chk;
    } beat_t;

    beat_t pend[$];
    beat_t sb[$];

    int m_ref;
    int m_fault;
    int act;        // 0 none, 1 push, 2 release, 3 fault (applied after the edge)
    beat_t act_beat;
    int stall;
    int errors;
    int checks;

    task automatic chk1(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, a, e, $time);
        end
    endtask

    // One clock cycle: apply last cycle's accepted beat to the model, check
    // the state-level outputs, drive new inputs and predict acceptance.
    task automatic cycle(input bit v, input bit trk, input logic [INS_W-1:0] ins,
                         input logic [CHK_W-1:0] cc, input bit pass, input bit ordy);
        bit fault_now;
        bit exp_rdy;
        @(posedge clk);
        #1;
        fault_now = 1'b0;
        case (act)
            1: begin
                pend.push_back(act_beat);
                if (m_ref < REF_MAX) m_ref++;
            end
            2: begin
                while (pend.size() > 0) sb.push_back(pend.pop_front());
            end
            3: begin
                pend.delete();
                sb.delete();
                m_ref = 0;
                if (m_fault < 255) m_fault++;
                fault_now = 1'b1;
                $display("fault  fault_cnt=%0d", m_fault);
            end
            default: ;
        endcase
        act = 0;

        chk1("alert", alert, fault_now);
        chk1("ref_cnt", ref_cnt, m_ref);
        chk1("fault_cnt", fault_cnt, m_fault);

        in_valid  = v;
        in_trk    = trk;
        in_ins    = ins;
        in_chk    = cc;
        pass_ok   = pass;
        out_ready = ordy;
        #1;
        exp_rdy = !fault_now && (sb.size() == 0) && (!trk || pend.size() < DEPTH);
        chk1("in_ready", in_ready, exp_rdy);

        if (v && exp_rdy) begin
            if (trk) begin
                act = 1;
                act_beat.ins = ins;
                act_beat.chk = cc;
            end else if (pend.size() > 0 && pass && m_ref >= THR) begin
                act = 2;
            end else begin
                act = 3;
            end
        end

`ifdef ICG_TIMEOUT_EN
        if (sb.size() > 0) begin
            if (ordy) begin
                stall = 0;
            end else begin
                stall++;
                if (stall == TO) begin
                    act = 3;
                    stall = 0;
                end
            end
        end else begin
            stall = 0;
        end
`endif
    endtask

    task automatic idle_cycle(input bit ordy);
        cycle(1'b0, 1'b0, '0, '0, 1'b0, ordy);
    endtask

    // Runs idle cycles until the model has nothing outstanding.
    task automatic drain(input bit toggle);
        int n;
        n = 0;
        while ((act != 0 || sb.size() > 0) && n < 60) begin
            idle_cycle(toggle ? n[0] : 1'b1);
            n++;
        end
        chk1("drain_timeout", (sb.size() > 0), 1'b0);
    endtask

    // Asynchronous reset applied in the middle of a cycle.
    task automatic mid_reset();
        @(posedge clk);
        #1;
        RST = 1'b1;
        #1;
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_ref_cnt", ref_cnt, 0);
        chk1("rst_fault_cnt", fault_cnt, 0);
        chk1("rst_alert", alert, 1'b0);
        pend.delete();
        sb.delete();
        act = 0;
        stall = 0;
        m_ref = 0;
        m_fault = 0;
        repeat (2) @(posedge clk);
        #1;
        RST = 1'b0;
        in_valid = 1'b0;
        in_trk = 1'b0;
        #1;
        chk1("rst_in_ready", in_ready, 1'b1);
    endtask

    // Monitor: every offered output beat must match the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (!RST) begin
                chk1("out_valid", out_valid, (sb.size() > 0));
                if (out_valid && sb.size() > 0) begin
                    chk1("out_ins", out_ins, sb[0].ins);
                    chk1("out_chk", out_chk, sb[0].chk);
                    if (out_ready) begin
                        $display("beat   ins=%h chk=%h", out_ins, out_chk);
                        void'(sb.pop_front());
                    end
                end else if (!out_valid) begin
                    chk1("idle_ins", out_ins, 0);
                    chk1("idle_chk", out_chk, 0);
                end
            end
        end
    end

    initial begin
        errors = 0;
        checks = 0;
        act = 0;
        stall = 0;
        m_ref = 0;
        m_fault = 0;
        RST = 1'b1;
        in_valid = 1'b0;
        in_trk = 1'b0;
        in_ins = '0;
        in_chk = '0;
        pass_ok = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        RST = 1'b0;
        #1;
        chk1("reset_out_valid", out_valid, 1'b0);
        chk1("reset_out_ins", out_ins, 0);
        chk1("reset_alert", alert, 1'b0);
        chk1("reset_fault_cnt", fault_cnt, 0);
        chk1("reset_ref_cnt", ref_cnt, 0);
        chk1("reset_in_ready", in_ready, 1'b1);

        // Release request straight after reset faults.
        cycle(1'b1, 1'b0, 64'h0, 16'h0, 1'b1, 1'b1);
        idle_cycle(1'b1);
        idle_cycle(1'b1);

        // Three tracked beats then a legal release: A/1, B/2, C/3 in order.
        cycle(1'b1, 1'b1, 64'hAAAA_0000_0000_000A, 16'd1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 64'hBBBB_0000_0000_000B, 16'd2, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 64'hCCCC_0000_0000_000C, 16'd3, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 64'h0, 16'h0, 1'b1, 1'b1);
        drain(1'b0);
        idle_cycle(1'b1);

        // Clear ref via a fault, then two tracked beats are below threshold.
        cycle(1'b1, 1'b0, 64'h0, 16'h0, 1'b1, 1'b1);
        idle_cycle(1'b1);
        cycle(1'b1, 1'b1, 64'h1111, 16'h11, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 64'h2222, 16'h22, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 64'h0, 16'h0, 1'b1, 1'b1);
        idle_cycle(1'b1);
        idle_cycle(1'b1);

        // Full FIFO: fifth tracked beat stalls, release still accepted.
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 1'b1, {32'hF0F0_0000, 32'(i)}, 16'(16'h100 + i), 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 64'h0, 16'h0, 1'b1, 1'b0);
        drain(1'b1);
        idle_cycle(1'b1);

        // Reset in the middle of a release.
        cycle(1'b1, 1'b1, 64'h5555, 16'h55, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 64'h0, 16'h0, 1'b1, 1'b0);
        idle_cycle(1'b0);
        idle_cycle(1'b0);
        mid_reset();

`ifdef ICG_TIMEOUT_EN
        // Downstream never accepts: watchdog faults after TO stalled cycles.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 1'b1, 64'(64'h7700 + i), 16'(i), 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 64'h0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < TO + 3; i++) idle_cycle(1'b0);
`endif

        // Randomised traffic.
        for (int i = 0; i < 2500; i++) begin
            cycle($urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) < 7,
                  {$urandom, $urandom},
                  16'($urandom),
                  $urandom_range(0, 7) != 0,
                  $urandom_range(0, 2) != 0);
        end
        drain(1'b0);
        idle_cycle(1'b1);

        // Fault counter saturation.
        for (int i = 0; i < 560; i++) cycle(1'b1, 1'b0, 64'h0, 16'h0, 1'b1, 1'b1);
        idle_cycle(1'b1);
        idle_cycle(1'b1);
        chk1("fault_cnt_sat", fault_cnt, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
